// File: rtl/ghr_spec.sv
// Global branch history unit: speculative and architectural history registers,
// misprediction repair, pending-branch counter and PHT index (raw or gshare).
module ghr_spec #(
  parameter int                  HIST_LEN   = 8,
  parameter int                  IDX_W      = 8,
  parameter int                  MODE       = 0,
  parameter int                  MAX_PEND   = 15,
  parameter logic [HIST_LEN-1:0] RESET_HIST = HIST_LEN'(2'b01)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            stall_f_i,
  input  logic                            branch_f_i,
  input  logic                            pred_taken_f_i,
  input  logic [31:0]                     pc_f_i,
  input  logic                            stall_e_i,
  input  logic [1:0]                      branch_op_e_i,
  input  logic                            pc_src_res_e_i,
  input  logic                            mispredict_e_i,
  output logic [HIST_LEN-1:0]             spec_hist_o,
  output logic [HIST_LEN-1:0]             arch_hist_o,
  output logic [IDX_W-1:0]                pht_idx_o,
  output logic [$clog2(MAX_PEND+1)-1:0]   pending_o
);

  localparam int                PEND_W   = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  if (HIST_LEN < 2 || MODE < 0 || MODE > 1 || IDX_W < 1 || IDX_W > 30 || MAX_PEND < 1)
  begin : g_bad_param
    $error("ghr_spec: unsupported parameter values");
  end

  logic                spec_upd;
  logic                resolve;
  logic                repair;
  logic [HIST_LEN-1:0] spec_hist;
  logic [HIST_LEN-1:0] arch_hist;
  logic [HIST_LEN-1:0] arch_next;
  logic [PEND_W-1:0]   pending;
  logic [IDX_W-1:0]    hist_idx;

  assign spec_upd  = branch_f_i & ~stall_f_i;
  assign resolve   = branch_op_e_i[0] & ~stall_e_i;
  assign repair    = resolve & mispredict_e_i;
  assign arch_next = resolve ? {arch_hist[HIST_LEN-2:0], pc_src_res_e_i} : arch_hist;

  // NOTE: sequential state uses non-blocking assignments so the repair path
  // copies the arch_next computed from pre-edge values, not a half-updated one.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      spec_hist <= RESET_HIST;
      arch_hist <= RESET_HIST;
    end else begin
      arch_hist <= arch_next;
      if (repair)
        spec_hist <= arch_next;        // same-cycle fetch is wrong-path
      else if (spec_upd)
        spec_hist <= {spec_hist[HIST_LEN-2:0], pred_taken_f_i};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending <= '0;
    end else if (repair) begin
      pending <= '0;
    end else if (spec_upd && !resolve) begin
      if (pending != PEND_MAX)
        pending <= pending + PEND_W'(1);
    end else if (resolve && !spec_upd) begin
      if (pending != '0)
        pending <= pending - PEND_W'(1);
    end
  end

  if (IDX_W <= HIST_LEN) begin : g_idx_trunc
    assign hist_idx = spec_hist[IDX_W-1:0];
  end else begin : g_idx_ext
    assign hist_idx = {{(IDX_W-HIST_LEN){1'b0}}, spec_hist};
  end

  if (MODE == 1) begin : g_gshare
    assign pht_idx_o = pc_f_i[IDX_W+1:2] ^ hist_idx;
  end else begin : g_raw
    assign pht_idx_o = hist_idx;
  end

  assign spec_hist_o = spec_hist;
  assign arch_hist_o = arch_hist;
  assign pending_o   = pending;

  // Bits that only some parameterisations consume.
  logic unused_bits;
  assign unused_bits = ^{pc_f_i, branch_op_e_i[1], spec_hist};

endmodule

// File: doc/ghr_spec.md
# ghr_spec

Parametrised global branch history unit replacing the fixed 2-bit history state machine in the branch predictor. It keeps two shift registers: a speculative history, updated at fetch from predictions, and an architectural history, updated at execute from resolved outcomes. On a misprediction it repairs the speculative copy from the architectural copy. It produces the pattern-history-table index used in fetch, either raw history or gshare (PC XOR history).

## Interface
- HIST_LEN, 8, history length in bits (≥2)
- IDX_W, 8, PHT index width (≥1)
- MODE, 0, index mode: 0 = raw history, 1 = gshare
- MAX_PEND, 15, saturation limit of the pending-branch counter (≥1)
- RESET_HIST, 'b01 zero-extended to HIST_LEN, reset value of both histories
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- stall_f_i  in  1  fetch stage stalled
- branch_f_i  in  1  conditional branch predicted in fetch this cycle
- pred_taken_f_i  in  1  prediction for that branch
- pc_f_i  in  32  fetch PC
- stall_e_i  in  1  execute stage stalled
- branch_op_e_i  in  2  branch op in execute; bit 0 = conditional branch
- pc_src_res_e_i  in  1  resolved outcome, 1 = taken
- mispredict_e_i  in  1  resolved outcome differs from prediction
- spec_hist_o  out  HIST_LEN  speculative history, bit 0 = newest
- arch_hist_o  out  HIST_LEN  architectural history, bit 0 = newest
- pht_idx_o  out  IDX_W  PHT index for fetch
- pending_o  out  $clog2(MAX_PEND+1)  count of speculatively recorded, unresolved branches

## Operation
- spec_upd = branch_f_i & ~stall_f_i; resolve = branch_op_e_i[0] & ~stall_e_i; repair = resolve & mispredict_e_i.
- mispredict_e_i is ignored when resolve = 0.
- arch_next = {arch_hist[HIST_LEN-2:0], pc_src_res_e_i} when resolve; otherwise arch_hist is held.
- Speculative history, by priority:
  - repair: spec_hist <= arch_next. A same-cycle spec_upd is wrong-path and is dropped.
  - else spec_upd: spec_hist <= {spec_hist[HIST_LEN-2:0], pred_taken_f_i}.
  - else: hold.
- Pending counter:
  - repair: set to 0.
  - else spec_upd and resolve together: unchanged.
  - else spec_upd only: +1, saturating at MAX_PEND.
  - else resolve only: −1, floored at 0.
- Index:
  - H = spec_hist_o truncated or zero-extended to IDX_W.
  - MODE 0: pht_idx_o = H.
  - MODE 1: pht_idx_o = pc_f_i[IDX_W+1:2] ^ H.
- Reset asserted: spec_hist_o = arch_hist_o = RESET_HIST, pending_o = 0, pht_idx_o reflects RESET_HIST immediately.
- Unsupported parameter values (HIST_LEN<2, MODE>1) are flagged by an elaboration-time assertion.

## Timing
- All state updates on the rising clk_i edge. Outputs are visible in the cycle after the triggering inputs.
- pht_idx_o is combinational from registered spec_hist and live pc_f_i; there is no register on the index path.
- Repair latency is 1 cycle. In the cycle after repair, spec_hist_o = arch_hist_o.
- Stall gating is per stage:
  - stall_f_i blocks only speculative updates.
  - stall_e_i blocks resolve, and therefore repair.
- Reset assertion clears state asynchronously, mid-operation included. Deassertion takes effect at the next clock edge; no update happens on the edge where reset_n_i is low.
- Pending saturation does not block history shifting. The counter is a status output only.

## Test plan
- Reset: HIST_LEN=8, MODE=0. Assert reset_n_i low mid-cycle -> spec_hist_o = arch_hist_o = 8'h01, pending_o = 0, pht_idx_o = 8'h01, all without waiting for a clock edge.
- Speculative shift: from reset, fetch 3 branches predicted T,N,T (stall_f_i = 0) -> spec_hist_o = 8'h0D, arch_hist_o = 8'h01, pending_o = 3.
- Resolve, no mispredict: resolve 3 branches T,N,T with mispredict_e_i = 0 -> arch_hist_o = 8'h0D, spec_hist_o unchanged at 8'h0D, pending_o = 0.
- Repair with simultaneous fetch:
  - Setup: spec = 8'h0D, arch = 8'h01, pending = 3.
  - Stimulus: resolve N with mispredict_e_i = 1 and branch_f_i = 1, pred T in the same cycle.
  - Response: arch = 8'h02, spec = 8'h02, pending = 0.
- Stall gating: stall_e_i = 1 with branch_op_e_i = 2'b01 and mispredict_e_i = 1 -> no change to arch, spec or pending. Repeat with stall_f_i = 1 and branch_f_i = 1 -> spec_hist_o held.
- Gshare and saturation:
  - MODE=1, IDX_W=8, spec = 8'h0D, pc_f_i = 32'h0000_0400 -> pht_idx_o = 8'h00 ^ 8'h0D = 8'h0D; pc_f_i = 32'h0000_03FC -> pht_idx_o = 8'hFF ^ 8'h0D = 8'hF2.
  - With MAX_PEND=3, 5 consecutive spec_upd -> pending_o holds at 3.
